// File: rtl/key_ctrl_fsm.sv
// Key-driven control for clock/calendar editing: set-mode FSM, edit cursor,
// increment/commit/abort strobes and time/date display select.
module key_ctrl_fsm #(
    parameter int DIGITS       = 6,
    parameter int CUR_W        = 3,
    parameter int IDLE_TIMEOUT = 500_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_mode,
    input  logic             key_move,
    input  logic             key_add,
    input  logic             key_switch,
    output logic [1:0]       set_mode,
    output logic [CUR_W-1:0] cursor,
    output logic             inc_pulse,
    output logic             commit_pulse,
    output logic [1:0]       commit_sel,
    output logic             abort_pulse,
    output logic             disp_sel
);

    localparam int CNT_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CUR_W-1:0] CUR_MAX = CUR_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_DATE  = 2'd2,
        SET_ALARM = 2'd3
    } mode_t;

    mode_t            state_q, state_d, state_nxt;
    logic [CUR_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       csel_q, csel_d;
    logic             disp_q, disp_d;
    logic             inc_q, inc_d;
    logic             commit_q, commit_d;
    logic             abort_q, abort_d;
    logic [3:0]       k_q, k_prev, press;
    logic             in_set, timeout;

    // bit order {mode, move, add, switch}; 1->0 edge of the registered level
    assign press   = k_prev & ~k_q;
    assign in_set  = (state_q != RUN);
    assign timeout = in_set && (cnt_q == CNT_MAX);

    always_comb begin
        state_nxt = RUN;
        unique case (state_q)
            RUN:       state_nxt = SET_TIME;
            SET_TIME:  state_nxt = SET_DATE;
            SET_DATE:  state_nxt = SET_ALARM;
            SET_ALARM: state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = '0;
        csel_d   = csel_q;
        disp_d   = disp_q;
        inc_d    = 1'b0;
        commit_d = 1'b0;
        abort_d  = 1'b0;
        if (in_set) begin
            cnt_d = cnt_q + 1'b1;
        end
        // a mode press beats a timeout landing in the same cycle
        priority case (1'b1)
            press[3]: begin
                state_d = state_nxt;
                cur_d   = '0;
                cnt_d   = '0;
                if (in_set) begin
                    commit_d = 1'b1;
                    csel_d   = state_q;
                end
            end
            timeout: begin
                state_d = RUN;
                cur_d   = '0;
                cnt_d   = '0;
                abort_d = 1'b1;
            end
            press[2]: begin
                if (in_set) begin
                    cur_d = (cur_q == CUR_MAX) ? '0 : cur_q + 1'b1;
                    cnt_d = '0;
                end
            end
            press[1]: begin
                if (in_set) begin
                    inc_d = 1'b1;
                    cnt_d = '0;
                end
            end
            press[0]: begin
                if (!in_set) begin
                    disp_d = ~disp_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '1;
            k_prev   <= '1;
            state_q  <= RUN;
            cur_q    <= '0;
            cnt_q    <= '0;
            csel_q   <= '0;
            disp_q   <= 1'b0;
            inc_q    <= 1'b0;
            commit_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            k_q      <= {key_mode, key_move, key_add, key_switch};
            k_prev   <= k_q;
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            csel_q   <= csel_d;
            disp_q   <= disp_d;
            inc_q    <= inc_d;
            commit_q <= commit_d;
            abort_q  <= abort_d;
        end
    end

    assign set_mode     = state_q;
    assign cursor       = cur_q;
    assign inc_pulse    = inc_q;
    assign commit_pulse = commit_q;
    assign commit_sel   = csel_q;
    assign abort_pulse  = abort_q;
    assign disp_sel     = disp_q;

endmodule
